// File: rtl/bus_monitor_capture.sv
// bus_monitor_capture
//
// Captures completed 6502 bus cycles and presents the most recent one on the
// six-digit debug display (address on HEX5..HEX2, data on HEX1..HEX0). The
// live display only updates on a slow refresh tick so it stays readable.
// A hardware breakpoint freezes the display on a matching address and asks
// the CPU to halt. Single-step and resume controls release the halt.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   bus_valid         one-cycle strobe for a completed bus cycle
//   bus_addr/data/rw  contents of the strobed cycle (rw: 1 = read)
//   bp_en, bp_addr    breakpoint enable and address (levels)
//   resume, step      one-cycle control pulses (already debounced)
//   digits            six 4-bit digit values {addr[15:0], data[7:0]}
//   rw_led            rw flag of the displayed cycle
//   halt              CPU halt request
//   trap              high while frozen at a breakpoint or step point
module bus_monitor_capture #(
  parameter int REFRESH_DIV = 5_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_data,
  input  logic        bus_rw,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic        resume,
  input  logic        step,
  output logic [23:0] digits,
  output logic        rw_led,
  output logic        halt,
  output logic        trap
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    RUN,
    TRAPPED,
    STEP
  } state_t;

  state_t        state;
  logic [CW-1:0] refresh_cnt;
  logic          tick;
  logic          skip;
  logic [15:0]   shadow_addr;
  logic [7:0]    shadow_data;
  logic          shadow_rw;
  logic          bp_match;

  assign tick = (refresh_cnt == CW'(REFRESH_DIV - 1));

  // The cycle right after a resume is exempt from the compare so the CPU
  // can execute past the instruction it was stopped on.
  assign bp_match = bus_valid & bp_en & (bus_addr == bp_addr) & ~skip;

  // Free-running refresh divider; it keeps counting while frozen so the
  // tick phase is independent of the debug state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Capture/debug state machine. halt and trap are registered alongside the
  // state so they change on the same edge as the state they decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      skip        <= 1'b0;
      shadow_addr <= '0;
      shadow_data <= '0;
      shadow_rw   <= 1'b0;
      digits      <= '0;
      rw_led      <= 1'b0;
      halt        <= 1'b0;
      trap        <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus_valid) begin
            shadow_addr <= bus_addr;
            shadow_data <= bus_data;
            shadow_rw   <= bus_rw;
            skip        <= 1'b0;
          end
          // A breakpoint hit outranks the refresh tick. A tick coinciding
          // with a strobe shows the incoming cycle rather than stale shadow.
          if (bp_match) begin
            digits <= {bus_addr, bus_data};
            rw_led <= bus_rw;
            state  <= TRAPPED;
            halt   <= 1'b1;
            trap   <= 1'b1;
          end else if (tick) begin
            if (bus_valid) begin
              digits <= {bus_addr, bus_data};
              rw_led <= bus_rw;
            end else begin
              digits <= {shadow_addr, shadow_data};
              rw_led <= shadow_rw;
            end
          end
        end

        TRAPPED: begin
          if (resume) begin
            state <= RUN;
            skip  <= 1'b1;
            halt  <= 1'b0;
            trap  <= 1'b0;
          end else if (step) begin
            state <= STEP;
            halt  <= 1'b0;
            trap  <= 1'b0;
          end
        end

        STEP: begin
          if (resume) begin
            state <= RUN;
            skip  <= 1'b1;
          end else if (bus_valid) begin
            // The stepped cycle is captured unconditionally, no compare.
            shadow_addr <= bus_addr;
            shadow_data <= bus_data;
            shadow_rw   <= bus_rw;
            digits      <= {bus_addr, bus_data};
            rw_led      <= bus_rw;
            state       <= TRAPPED;
            halt        <= 1'b1;
            trap        <= 1'b1;
          end
        end

        default: begin
          state <= RUN;
          halt  <= 1'b0;
          trap  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_monitor_capture.sv
// Testbench for bus_monitor_capture: directed scenarios followed by a random
// phase, every cycle compared against a behavioural model of the monitor.
module tb_bus_monitor_capture;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_valid;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;
  logic        bus_rw;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic        resume;
  logic        step;
  logic [23:0] digits;
  logic        rw_led;
  logic        halt;
  logic        trap;

  int testsRun = 0;
  int testsFailed = 0;

  bus_monitor_capture #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .resume(resume), .step(step),
    .digits(digits), .rw_led(rw_led), .halt(halt), .trap(trap)
  );

  always #5 clk = ~clk;

  // Behavioural model: edges since reset, whether frozen, whether waiting
  // for a stepped cycle, the latest seen cycle and the displayed cycle.
  int          edgesSeen;
  logic        mFrozen;
  logic        mStepping;
  logic        mSkip;
  logic [15:0] mLastAddr, mShowAddr;
  logic [7:0]  mLastData, mShowData;
  logic        mLastRw, mShowRw;

  task automatic modelReset();
    edgesSeen = 0;
    mFrozen = 0; mStepping = 0; mSkip = 0;
    mLastAddr = 0; mLastData = 0; mLastRw = 0;
    mShowAddr = 0; mShowData = 0; mShowRw = 0;
  endtask

  task automatic modelEdge();
    logic refreshNow;
    refreshNow = ((edgesSeen % DIV) == DIV - 1);
    edgesSeen++;
    if (mFrozen) begin
      if (resume) begin
        mFrozen = 0; mSkip = 1;
      end else if (step) begin
        mFrozen = 0; mStepping = 1;
      end
    end else if (mStepping) begin
      if (resume) begin
        mStepping = 0; mSkip = 1;
      end else if (bus_valid) begin
        mLastAddr = bus_addr; mLastData = bus_data; mLastRw = bus_rw;
        mShowAddr = bus_addr; mShowData = bus_data; mShowRw = bus_rw;
        mStepping = 0; mFrozen = 1;
      end
    end else begin
      logic hit;
      hit = bus_valid && bp_en && (bus_addr == bp_addr) && !mSkip;
      if (bus_valid) begin
        mLastAddr = bus_addr; mLastData = bus_data; mLastRw = bus_rw;
        mSkip = 0;
      end
      if (hit || refreshNow) begin
        mShowAddr = mLastAddr; mShowData = mLastData; mShowRw = mLastRw;
      end
      if (hit) mFrozen = 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] observed,
                             input logic [23:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".digits"}, digits, {mShowAddr, mShowData});
    checkOutput({tag, ".rw_led"}, {23'd0, rw_led}, {23'd0, mShowRw});
    checkOutput({tag, ".halt"}, {23'd0, halt}, {23'd0, mFrozen});
    checkOutput({tag, ".trap"}, {23'd0, trap}, {23'd0, mFrozen});
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, then
  // compare just after the edge and drop the one-cycle strobes.
  task automatic applyStimulus(input string tag, input logic v, input logic [15:0] a,
                               input logic [7:0] d, input logic rw,
                               input logic res, input logic stp);
    bus_valid = v; bus_addr = a; bus_data = d; bus_rw = rw;
    resume = res; step = stp;
    @(posedge clk);
    modelEdge();
    #1;
    bus_valid = 0; resume = 0; step = 0;
    checkAll(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, 16'h0, 8'h0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; bus_valid = 0; bus_addr = 0; bus_data = 0; bus_rw = 0;
    bp_en = 0; bp_addr = 0; resume = 0; step = 0;
    modelReset();
    #12;
    checkOutput("reset.digits", digits, 24'h0);
    checkOutput("reset.halt", {23'd0, halt}, 24'h0);
    #8 rst = 0;

    // Live capture and rate limiting
    applyStimulus("live", 1, 16'h1234, 8'hAB, 1, 0, 0);
    idle("live_wait", 2);
    checkOutput("live.before_tick", digits, 24'h0);
    idle("live_tick", 1);
    checkOutput("live.after_tick", digits, 24'h1234AB);
    applyStimulus("live2", 1, 16'h5555, 8'h66, 0, 0, 0);
    idle("live2_wait", 5);

    // Breakpoint
    bp_en = 1; bp_addr = 16'hC000;
    applyStimulus("bp_8000", 1, 16'h8000, 8'h11, 1, 0, 0);
    applyStimulus("bp_8001", 1, 16'h8001, 8'h22, 1, 0, 0);
    applyStimulus("bp_c000", 1, 16'hC000, 8'h4C, 1, 0, 0);
    checkOutput("bp.digits_const", digits, 24'hC0004C);
    checkOutput("bp.halt_const", {23'd0, halt}, 24'h1);
    applyStimulus("bp_ignored", 1, 16'h9999, 8'h99, 0, 0, 0);
    idle("bp_frozen", 6);
    checkOutput("bp.frozen_const", digits, 24'hC0004C);

    // Resume: next C000 is skipped, a later one traps
    applyStimulus("resume", 0, 16'h0, 8'h0, 0, 1, 0);
    checkOutput("resume.halt_const", {23'd0, halt}, 24'h0);
    applyStimulus("skip_c000", 1, 16'hC000, 8'h4C, 1, 0, 0);
    checkOutput("skip.halt_const", {23'd0, halt}, 24'h0);
    applyStimulus("run_1000", 1, 16'h1000, 8'h01, 0, 0, 0);
    applyStimulus("retrap", 1, 16'hC000, 8'h77, 1, 0, 0);
    checkOutput("retrap.trap_const", {23'd0, trap}, 24'h1);

    // Single step
    applyStimulus("step", 0, 16'h0, 8'h0, 0, 0, 1);
    idle("step_gap", 2);
    applyStimulus("step_cap", 1, 16'hC001, 8'hEA, 1, 0, 0);
    checkOutput("step.digits_const", digits, 24'hC001EA);
    checkOutput("step.halt_const", {23'd0, halt}, 24'h1);

    // Resume and step together: resume wins
    applyStimulus("res_and_step", 0, 16'h0, 8'h0, 0, 1, 1);
    applyStimulus("clear_skip", 1, 16'h2000, 8'h20, 0, 0, 0);

    // Matching strobe coincident with a refresh tick
    for (int i = 0; i < DIV && (edgesSeen % DIV) != DIV - 1; i++) idle("align", 1);
    applyStimulus("bp_on_tick", 1, 16'hC000, 8'h5A, 0, 0, 0);
    checkOutput("bp_on_tick.digits_const", digits, 24'hC0005A);

    // Asynchronous reset in TRAPPED, mid-cycle
    #1 rst = 1;
    #1;
    checkOutput("async_rst.digits", digits, 24'h0);
    checkOutput("async_rst.halt", {23'd0, halt}, 24'h0);
    checkOutput("async_rst.trap", {23'd0, trap}, 24'h0);
    modelReset();
    #2 rst = 0;
    applyStimulus("post_rst", 1, 16'hABCD, 8'hEF, 1, 0, 0);
    idle("post_rst_wait", 4);

    // Random phase
    for (int n = 0; n < 400; n++) begin
      logic        v, rw, res, stp;
      logic [15:0] a;
      int          sel;
      v   = ($urandom_range(0, 3) != 0);
      rw  = $urandom_range(0, 1);
      res = ($urandom_range(0, 9) == 0);
      stp = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 3);
      if (sel == 0) a = bp_addr;
      else if (sel == 1) a = bp_addr + 16'd1;
      else a = 16'($urandom);
      if (n % 50 == 49) bp_en = ~bp_en;
      applyStimulus("random", v, a, 8'($urandom), rw, res, stp);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bus_monitor_capture.md
# bus_monitor_capture

Captures 6502 bus cycles for the DE10-Lite debug display and drives six 4-bit digit values into the per-digit 7-segment converters (HEX5..HEX0 = address[15:0], data[7:0]). The live display is rate-limited to a readable refresh rate. A hardware breakpoint freezes the display on a matching address and requests a CPU halt, and single-step and resume controls are provided. It sits between the CPU bus interface and the six segment converters; its halt output feeds the CPU clock-enable logic.

## Interface
- REFRESH_DIV, 5_000_000: clk cycles per display refresh tick (10 Hz at 50 MHz); must be ≥2.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus_valid  in  1  one-cycle strobe marking a completed CPU bus cycle.
- bus_addr  in  16  address of the strobed cycle.
- bus_data  in  8  data of the strobed cycle.
- bus_rw  in  1  1 = read, 0 = write.
- bp_en  in  1  breakpoint enable (level).
- bp_addr  in  16  breakpoint address (level).
- resume  in  1  one-cycle pulse, already synchronized and debounced.
- step  in  1  one-cycle pulse, already synchronized and debounced.
- digits  out  24  [23:20]=addr[15:12] … [11:8]=addr[3:0], [7:4]=data[7:4], [3:0]=data[3:0].
- rw_led  out  1  bus_rw of the displayed cycle.
- halt  out  1  CPU halt request.
- trap  out  1  high while frozen at a breakpoint or step point.

## Operation
- Registers:
  - shadow {addr, data, rw}: loaded on every accepted bus_valid.
  - display {digits, rw_led}.
  - refresh counter.
  - skip flag.
  - state.
- Refresh counter: counts 0..REFRESH_DIV-1 continuously in all states, then wraps; tick = 1 in the cycle the count equals REFRESH_DIV-1.
- States:
  - RUN:
    - bus_valid loads shadow.
    - tick loads display from shadow; if bus_valid arrives in the same cycle, the display takes the incoming bus values (bypass).
    - Breakpoint match = bus_valid & bp_en & (bus_addr == bp_addr) & ~skip. On a match, shadow and display are loaded with the incoming cycle, and the next state is TRAPPED.
    - Any bus_valid clears skip.
  - TRAPPED:
    - halt = 1, trap = 1; display is frozen.
    - bus_valid is ignored (no shadow or display load).
    - resume → RUN with skip = 1.
    - step → STEP.
    - resume and step together: resume wins.
  - STEP:
    - halt = 0, trap = 0.
    - The first bus_valid loads shadow and display, with no address compare, and the next state is TRAPPED.
    - resume → RUN (skip = 1).
- Skip flag: exempts the first bus cycle after a resume from the breakpoint compare, so execution does not re-trap on the same instruction.
- Priority within RUN in a single cycle: breakpoint match > tick.
- Outputs halt and trap are registered decodes of state.

## Timing
- Reset values:
  - Outputs: digits = 24'h000000, rw_led = 0, halt = 0, trap = 0.
  - Internal: shadow = 0, counter = 0, skip = 0, state = RUN.
- Reset mid-operation (any state) returns to these values immediately (asynchronous); the counter restarts from 0 after release.
- Live latency: a bus_valid in cycle N is visible on digits at the earliest after the edge ending cycle N (coincident tick), and at the latest after the next tick edge.
- Breakpoint:
  - A matching bus_valid in cycle N makes digits, halt and trap valid after the edge ending cycle N (1-cycle latency).
  - Bus cycles arriving while halt propagates are ignored.
- Resume: a pulse in cycle N takes halt low after the edge ending N.
- Step: a pulse in cycle N takes halt low after the edge ending N. The captured cycle M makes halt high again after the edge ending M.
- Refresh ticks in TRAPPED and STEP have no effect.

## Test plan
- Reset, REFRESH_DIV=4: drive bus_valid with addr 16'h1234, data 8'hAB, rw 1 in cycle 1 → digits stays 0 until the first tick, then 24'h1234AB with rw_led = 1; no update between ticks.
- Breakpoint match: bp_en = 1, bp_addr = 16'hC000, bus sequence 8000/8001/C000 (data 8'h4C) → one cycle after the C000 strobe, digits = 24'hC0004C, halt = 1, trap = 1. Further strobes and ticks leave digits unchanged.
- Resume from trap: pulse resume, then the next strobe is C000 again → no re-trap (skip), halt = 0. A later C000 strobe traps.
- Single step while trapped: pulse step, strobe addr C001, data 8'hEA → halt drops for the interval, then digits = 24'hC001EA, halt = 1, trap = 1.
- Simultaneous events:
  - Matching strobe coincident with a tick → TRAPPED with the matched values.
  - resume and step in the same cycle → RUN.
- Asynchronous reset asserted mid-cycle in TRAPPED → all outputs go to 0 before the next clock edge; normal live operation resumes after release.
